// File: rtl/vx_ahb_line_subordinate_pkg.sv
// Shared types for the AHB line subordinate: transfer encodings, word size and FSM states.
package VX_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    DONE,
    ERR1,
    ERR2
  } sub_state_t;

endpackage

// File: rtl/vx_ahb_line_subordinate_if.sv
// AHB-Lite bus plus Vortex line memory port; slave = subordinate view, master = manager/memory side.
interface vx_ahb_line_subordinate_if #(
  parameter int VX_DATA_WIDTH  = 512,
  parameter int VX_ADDR_WIDTH  = 26,
  parameter int VX_TAG_WIDTH   = 8,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
);
  logic                        HSEL;
  logic [AHB_ADDR_WIDTH-1:0]   HADDR;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic [2:0]                  HSIZE;
  logic [AHB_DATA_WIDTH-1:0]   HWDATA;
  logic                        HREADY;
  logic                        HREADYOUT;
  logic                        HRESP;
  logic [AHB_DATA_WIDTH-1:0]   HRDATA;

  logic                        mem_req_valid;
  logic                        mem_req_rw;
  logic [VX_DATA_WIDTH/8-1:0]  mem_req_byteen;
  logic [VX_ADDR_WIDTH-1:0]    mem_req_addr;
  logic [VX_DATA_WIDTH-1:0]    mem_req_data;
  logic [VX_TAG_WIDTH-1:0]     mem_req_tag;
  logic                        mem_req_ready;
  logic                        mem_rsp_valid;
  logic [VX_DATA_WIDTH-1:0]    mem_rsp_data;
  logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag;
  logic                        mem_rsp_ready;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_ahb_line_subordinate_line_buf.sv
// Single-line buffer: data, tag, valid and per-byte dirty mask; async word read, word write, line load.
module vx_ahb_line_buf #(
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  parameter int TAG_W  = 26,
  parameter int WORDS  = LINE_W / WORD_W,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [WORD_W-1:0]   rd_word,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [WORD_W-1:0]   wr_dat,
  input  logic                load_en,
  input  logic [TAG_W-1:0]    load_tag,
  input  logic [LINE_W-1:0]   load_line,
  output logic [TAG_W-1:0]    tag,
  output logic                valid,
  output logic [LINE_W/8-1:0] dirty,
  output logic [LINE_W-1:0]   line
);
  localparam int WB = WORD_W / 8;

  // Line data carries no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (load_en)
      line <= load_line;
    else if (wr_en)
      line[wr_idx*WORD_W +: WORD_W] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag   <= '0;
      valid <= 1'b0;
      dirty <= '0;
    end else if (load_en) begin
      tag   <= load_tag;
      valid <= 1'b1;
      dirty <= '0;
    end else if (wr_en) begin
      dirty[wr_idx*WB +: WB] <= '1;
    end
  end

  assign rd_word = line[rd_idx*WORD_W +: WORD_W];

endmodule

// File: rtl/vx_ahb_line_subordinate.sv
// AHB-Lite word subordinate backed by one 512b line buffer with writeback/fill over a line mem port.
// Optional address/size error response when VX_AHB_SUB_ERRCHK_EN is defined.
module vx_ahb_line_subordinate
  import VX_ahb_pkg::*;
#(
  parameter int VX_DATA_WIDTH  = 512,
  parameter int VX_ADDR_WIDTH  = 26,
  parameter int VX_TAG_WIDTH   = 8,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
) (
  input logic                      clk,
  input logic                      reset,
  vx_ahb_line_subordinate_if.slave bus
);
  localparam int WORDS = VX_DATA_WIDTH / AHB_DATA_WIDTH;
  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(VX_DATA_WIDTH / 8);

  sub_state_t                 state, state_nxt;
  htrans_t                    htrans;
  logic                       addr_sample, addr_err, addr_hit;
  logic                       dp_vld, dp_write, dp_hit;
  logic [VX_ADDR_WIDTH-1:0]   dp_line;
  logic [IDX_W-1:0]           dp_idx;
  logic [AHB_DATA_WIDTH-1:0]  hold_dat, wr_dat, rd_word;
  logic                       hold_ld, rd_en, wr_en, load_en, hreadyout, hresp;
  logic [VX_ADDR_WIDTH-1:0]   buf_tag;
  logic                       buf_valid;
  logic [VX_DATA_WIDTH/8-1:0] buf_dirty;
  logic [VX_DATA_WIDTH-1:0]   buf_line;
  logic                       unused_ok;

  assign unused_ok   = ^{bus.HSIZE, bus.HADDR[1:0], bus.mem_rsp_tag};
  assign htrans      = htrans_t'(bus.HTRANS);
  assign addr_sample = bus.HSEL && bus.HREADY && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign addr_hit    = buf_valid && (buf_tag == bus.HADDR[AHB_ADDR_WIDTH-1:OFF_W]);

`ifdef VX_AHB_SUB_ERRCHK_EN
  assign addr_err = addr_sample && (bus.HSIZE != HSIZE_WORD || bus.HADDR[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  // Data-phase context only advances while the bus is ready, so it survives miss wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_hit   <= 1'b0;
      dp_line  <= '0;
      dp_idx   <= '0;
      hold_dat <= '0;
    end else begin
      state <= state_nxt;
      if (bus.HREADY) begin
        dp_vld   <= addr_sample && !addr_err;
        dp_write <= bus.HWRITE;
        dp_hit   <= addr_hit;
        dp_line  <= bus.HADDR[AHB_ADDR_WIDTH-1:OFF_W];
        dp_idx   <= bus.HADDR[OFF_W-1:2];
      end
      if (hold_ld)
        hold_dat <= bus.HWDATA;
    end
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hold_ld   = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_dat    = bus.HWDATA;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (dp_vld && !dp_hit) begin
          hreadyout = 1'b0;
          hold_ld   = 1'b1;
          state_nxt = (|buf_dirty) ? WB_REQ : FILL_REQ;
        end else begin
          rd_en = dp_vld && !dp_write;
          wr_en = dp_vld && dp_write;
          if (addr_err) state_nxt = ERR1;
        end
      end
      WB_REQ: begin
        hreadyout = 1'b0;
        if (bus.mem_req_ready) state_nxt = FILL_REQ;
      end
      FILL_REQ: begin
        hreadyout = 1'b0;
        if (bus.mem_req_ready) state_nxt = FILL_WAIT;
      end
      FILL_WAIT: begin
        hreadyout = 1'b0;
        if (bus.mem_rsp_valid) begin
          load_en   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        rd_en     = !dp_write;
        wr_en     = dp_write;
        wr_dat    = hold_dat;
        state_nxt = addr_err ? ERR1 : IDLE;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp     = 1'b1;
        state_nxt = addr_err ? ERR1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  vx_ahb_line_buf #(
    .LINE_W (VX_DATA_WIDTH),
    .WORD_W (AHB_DATA_WIDTH),
    .TAG_W  (VX_ADDR_WIDTH)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (dp_idx),
    .rd_word   (rd_word),
    .wr_en     (wr_en),
    .wr_idx    (dp_idx),
    .wr_dat    (wr_dat),
    .load_en   (load_en),
    .load_tag  (dp_line),
    .load_line (bus.mem_rsp_data),
    .tag       (buf_tag),
    .valid     (buf_valid),
    .dirty     (buf_dirty),
    .line      (buf_line)
  );

  assign bus.HREADYOUT      = hreadyout;
  assign bus.HRESP          = hresp;
  assign bus.HRDATA         = rd_en ? rd_word : '0;
  assign bus.mem_req_valid  = (state == WB_REQ) || (state == FILL_REQ);
  assign bus.mem_req_rw     = (state == WB_REQ);
  assign bus.mem_req_addr   = (state == WB_REQ) ? buf_tag : dp_line;
  assign bus.mem_req_byteen = (state == WB_REQ) ? buf_dirty : '1;
  assign bus.mem_req_data   = buf_line;
  assign bus.mem_req_tag    = '0;
  assign bus.mem_rsp_ready  = (state == FILL_WAIT);

endmodule
